// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter that shares one mux2 between two
// valid/ready requesters and registers the selected word for downstream.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_1_valid/data/ready    requester 1 handshake (sel = 0)
//   in_2_valid/data/ready    requester 2 handshake (sel = 1)
//   sel                      mux2 select, equal to the current grant
//   out_valid/data/src       registered output word and its source
//   out_ready                downstream accepts out_data
// Optional (macro MUX2_ARB_STATS_EN):
//   stats_clr                synchronous clear of the grant counters
//   grant_cnt_1/2            saturating per-requester grant counters
module mux2_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_1_valid,
  input  logic [WIDTH-1:0] in_1_data,
  output logic             in_1_ready,
  input  logic             in_2_valid,
  input  logic [WIDTH-1:0] in_2_data,
  output logic             in_2_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] grant_cnt_1,
  output logic [CNT_W-1:0] grant_cnt_2
`endif
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;

  logic             grant;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // Slot is free, or its word leaves this cycle.
  assign load_en = !out_valid | out_ready;

  always_comb begin
    grant = last_grant_q;
    unique case (1'b1)
      (in_1_valid & in_2_valid):  grant = !last_grant_q;
      (in_1_valid & !in_2_valid): grant = 1'b0;
      (!in_1_valid & in_2_valid): grant = 1'b1;
      default:                    grant = last_grant_q;
    endcase
  end

  assign sel     = grant;
  assign mux_out = grant ? in_2_data : in_1_data;

  assign in_1_ready = load_en & in_1_valid & !grant;
  assign in_2_ready = load_en & in_2_valid & grant;
  assign xfer       = in_1_ready | in_2_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    if (xfer) begin
      state_d      = ST_FULL;
      last_grant_d = grant;
      out_data_d   = mux_out;
      out_src_d    = grant;
    end else if (out_valid & out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // last_grant resets to 1 so requester 1 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

`ifdef MUX2_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_1_q, cnt_1_d;
  logic [CNT_W-1:0] cnt_2_q, cnt_2_d;

  // Clear beats increment; counters stick at all-ones.
  always_comb begin
    cnt_1_d = cnt_1_q;
    cnt_2_d = cnt_2_q;
    if (stats_clr) begin
      cnt_1_d = '0;
      cnt_2_d = '0;
    end else begin
      if (in_1_ready && !(&cnt_1_q)) cnt_1_d = cnt_1_q + CNT_W'(1);
      if (in_2_ready && !(&cnt_2_q)) cnt_2_d = cnt_2_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_1_q <= '0;
      cnt_2_q <= '0;
    end else begin
      cnt_1_q <= cnt_1_d;
      cnt_2_q <= cnt_2_d;
    end
  end

  assign grant_cnt_1 = cnt_1_q;
  assign grant_cnt_2 = cnt_2_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed plus random stimulus with a queue
// scoreboard and a round-robin reference model.
module tb_mux2_rr_arbiter;

  localparam int W = 16;
`ifdef MUX2_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_1_valid = 1'b0;
  logic [W-1:0]  in_1_data = '0;
  logic          in_1_ready;
  logic          in_2_valid = 1'b0;
  logic [W-1:0]  in_2_data = '0;
  logic          in_2_ready;
  logic          sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_src;
  logic          out_ready = 1'b0;
  logic          stats_clr = 1'b0;
  logic [CW-1:0] grant_cnt_1;
  logic [CW-1:0] grant_cnt_2;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_1_valid (in_1_valid),
    .in_1_data  (in_1_data),
    .in_1_ready (in_1_ready),
    .in_2_valid (in_2_valid),
    .in_2_data  (in_2_data),
    .in_2_ready (in_2_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
`ifdef MUX2_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt_1(grant_cnt_1),
    .grant_cnt_2(grant_cnt_2)
`endif
  );

`ifndef MUX2_ARB_STATS_EN
  assign grant_cnt_1 = '0;
  assign grant_cnt_2 = '0;
`endif

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         src;
    logic [W-1:0] data;
  } ent_t;

  ent_t q[$];

  // Reference model state: who was served last, expected counters.
  logic   m_last = 1'b1;
  int     m_cnt1 = 0;
  int     m_cnt2 = 0;
  int     cmax = (1 << CW) - 1;

  always @(negedge rst_n) begin
    q.delete();
    m_last = 1'b1;
    m_cnt1 = 0;
    m_cnt2 = 0;
  end

  // Reference: decide the winner from the rules, check handshake,
  // then log the accepted word after the capturing edge.
  logic         p_go, p_g, p_clr;
  logic [W-1:0] p_d;
  always begin
    logic g, le, r1, r2;
    @(negedge clk);
    p_go = 1'b0;
    p_clr = 1'b0;
    if (rst_n) begin
      if (in_1_valid && in_2_valid) g = !m_last;
      else if (in_1_valid)          g = 1'b0;
      else if (in_2_valid)          g = 1'b1;
      else                          g = m_last;
      le = (q.size() == 0) || out_ready;
      r1 = le && in_1_valid && (g == 1'b0);
      r2 = le && in_2_valid && (g == 1'b1);
      chk("sel", 32'(sel), 32'(g));
      chk("in_1_ready", 32'(in_1_ready), 32'(r1));
      chk("in_2_ready", 32'(in_2_ready), 32'(r2));
      p_go  = r1 || r2;
      p_g   = g;
      p_d   = g ? in_2_data : in_1_data;
      p_clr = stats_clr;
    end
    @(posedge clk);
    if (rst_n) begin
      if (p_go) begin
        q.push_back('{src: p_g, data: p_d});
        m_last = p_g;
      end
      if (p_clr) begin
        m_cnt1 = 0;
        m_cnt2 = 0;
      end else if (p_go) begin
        if (!p_g && m_cnt1 < cmax) m_cnt1++;
        if (p_g && m_cnt2 < cmax) m_cnt2++;
      end
    end
  end

  // Monitor: compare the presented word, pop it when drained.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_src", 32'(out_src), 32'(q[0].src));
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("out_valid", 32'(out_valid), 32'd0);
      end
`ifdef MUX2_ARB_STATS_EN
      chk("grant_cnt_1", 32'(grant_cnt_1), 32'(m_cnt1));
      chk("grant_cnt_2", 32'(grant_cnt_2), 32'(m_cnt2));
`endif
    end
  end

  task automatic drive(input logic v1, input logic [W-1:0] d1,
                       input logic v2, input logic [W-1:0] d2,
                       input logic r);
    @(posedge clk);
    #1;
    in_1_valid = v1;
    in_1_data  = d1;
    in_2_valid = v2;
    in_2_data  = d2;
    out_ready  = r;
  endtask

  initial begin
    logic a1, a2;
    // Reset asserted with in_1 alone valid: grant 0 shows on sel.
    in_1_valid = 1'b1;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst sel", 32'(sel), 32'd0);
    in_1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 16'h00AD, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    repeat (4) drive(1, 16'h00AD, 1, 16'hBEEF, 1);
    drive(1, 16'h1234, 0, 0, 1);
    repeat (3) drive(1, 16'h0005, 1, 16'h0006, 0);
    drive(1, 16'h0005, 1, 16'h0006, 1);
    drive(1, 16'h0001, 0, 0, 1);
    drive(0, 0, 1, 16'h0002, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

`ifdef MUX2_ARB_STATS_EN
    for (int i = 0; i < 5; i++) drive(1, W'(i + 16'h0100), 0, 0, 1);
    stats_clr = 1'b1;
    drive(1, 16'h0200, 0, 0, 1);
    stats_clr = 1'b1;
    drive(0, 0, 0, 0, 1);
    stats_clr = 1'b0;
    drive(0, 0, 0, 0, 1);
`endif

    // Async reset mid-cycle while a word is held under backpressure.
    drive(1, 16'hAAAA, 1, 16'hBBBB, 0);
    drive(1, 16'hAAAA, 1, 16'hBBBB, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst out_data", 32'(out_data), 32'h0);
    in_1_valid = 1'b0;
    in_2_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic; requesters hold valid/data until accepted.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      a1 = in_1_valid & in_1_ready;
      a2 = in_2_valid & in_2_ready;
      @(posedge clk);
      #1;
      if (!in_1_valid || a1) begin
        in_1_valid = ($urandom_range(0, 3) != 0);
        in_1_data  = W'($urandom);
      end
      if (!in_2_valid || a2) begin
        in_2_valid = ($urandom_range(0, 3) != 0);
        in_2_data  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX2_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 19) == 0);
`endif
    end

    stats_clr = 1'b0;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
